// File: rtl/register_file_gen.sv
// register_file_gen: 2-read/1-write register file, reg 0 reads zero, storage cleared by a one-entry-per-cycle sweep.
// Reads are combinational, writes land at the edge (same-cycle forwarding when REGFILE_BYPASS_EN is defined); writes are dropped while busy.
module register_file_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              regWriteEn,
  input  logic [ADDR_W-1:0] writeAdr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readAdr1,
  input  logic [ADDR_W-1:0] readAdr2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_ok;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST_PTR) state_d = ST_IDLE;
        else                   ptr_d   = ptr_q + ADDR_W'(1);
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // The sweep and normal writes share the single storage write port.
  always_comb begin
    busy   = (state_q == ST_CLEAR);
    wr_ok  = regWriteEn && (state_q == ST_IDLE) && !clr &&
             (writeAdr != '0) && in_range(writeAdr);
    mem_we = busy || wr_ok;
    mem_wa = busy ? ptr_q : writeAdr;
    mem_wd = busy ? '0 : writeData;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (!busy && (a != '0) && in_range(a)) v = mem_q[a];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (a == writeAdr)) v = writeData;
`endif
    return v;
  endfunction

  always_comb begin
    readData1 = rd_port(readAdr1);
    readData2 = rd_port(readAdr2);
  end

endmodule
